// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory with req/done handshake, byte-lane writes, programmable wait states
// and out-of-range flagging. Optional macro DM_PERF_EN adds in-range read/write completion counters.
module data_mem_ctrl #(
    parameter int BIT_WIDTH   = 32,
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [BIT_WIDTH/8-1:0] be,
    input  logic [BIT_WIDTH-1:0]   wdata,
    output logic                   ready,
    output logic                   done,
    output logic                   err,
    output logic [BIT_WIDTH-1:0]   rdata
`ifdef DM_PERF_EN
    ,
    output logic [31:0]            rd_count,
    output logic [31:0]            wr_count
`endif
);

    localparam int NB = BIT_WIDTH / 8;
    // One extra bit so DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state;
    logic [3:0]             cnt;
    logic                   we_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [NB-1:0]          be_q;
    logic [BIT_WIDTH-1:0]   wdata_q;
    logic [BIT_WIDTH-1:0]   mem [DEPTH];
    logic                   in_range;
    logic                   access;

    assign ready    = (state == IDLE);
    assign in_range = ({1'b0, addr_q} < DEPTH_W);
    assign access   = (state == BUSY) && (cnt == 4'd0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            done    <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        be_q    <= be;
                        wdata_q <= wdata;
                        cnt     <= 4'(WAIT_STATES);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= IDLE;
                        done  <= 1'b1;
                        err   <= !in_range;
                        if (!we_q) rdata <= in_range ? mem[addr_q] : '0;
                    end
                end
            endcase
        end
    end

    // NOTE: the array has no reset; contents are undefined at power-up and survive rst.
    // An aborted write never reaches here because rst forces state to IDLE, clearing access.
    always_ff @(posedge clk) begin
        if (access && we_q && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (be_q[i]) mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

`ifdef DM_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count <= 32'd0;
            wr_count <= 32'd0;
        end else if (access && in_range) begin
            if (we_q) wr_count <= wr_count + 32'd1;
            else      rd_count <= rd_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: two instances (0 and 3 wait states, DEPTH=1000) driven
// with shared data inputs and per-instance req, checked every cycle against a transaction model.
module tb_data_mem_ctrl;

    localparam int BW    = 32;
    localparam int NB    = BW / 8;
    localparam int DEPTH = 1000;
    localparam int AW    = 10;
    localparam int WS_A  = 0;
    localparam int WS_B  = 3;

    logic           clk   = 1'b0;
    logic           rst   = 1'b1;
    logic [1:0]     req   = '0;
    logic           we    = 1'b0;
    logic [AW-1:0]  addr  = '0;
    logic [NB-1:0]  be    = '0;
    logic [BW-1:0]  wdata = '0;
    logic [1:0]     ready;
    logic [1:0]     done;
    logic [1:0]     err;
    logic [BW-1:0]  rdata [2];
`ifdef DM_PERF_EN
    logic [31:0]    rd_count [2];
    logic [31:0]    wr_count [2];
`endif

    int             n_tests = 0;
    int             n_fail  = 0;
    logic [BW-1:0]  mem_m   [2][DEPTH];
    logic [BW-1:0]  rdata_m [2];
    int unsigned    rd_m    [2];
    int unsigned    wr_m    [2];

    always #5 clk = ~clk;

    data_mem_ctrl #(.BIT_WIDTH(BW), .DEPTH(DEPTH), .ADDR_W(AW), .WAIT_STATES(WS_A)) dut_a (
        .clk(clk), .rst(rst), .req(req[0]), .we(we), .addr(addr), .be(be), .wdata(wdata),
        .ready(ready[0]), .done(done[0]), .err(err[0]), .rdata(rdata[0])
`ifdef DM_PERF_EN
        , .rd_count(rd_count[0]), .wr_count(wr_count[0])
`endif
    );

    data_mem_ctrl #(.BIT_WIDTH(BW), .DEPTH(DEPTH), .ADDR_W(AW), .WAIT_STATES(WS_B)) dut_b (
        .clk(clk), .rst(rst), .req(req[1]), .we(we), .addr(addr), .be(be), .wdata(wdata),
        .ready(ready[1]), .done(done[1]), .err(err[1]), .rdata(rdata[1])
`ifdef DM_PERF_EN
        , .rd_count(rd_count[1]), .wr_count(wr_count[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ws_of(input int i);
        return (i == 0) ? WS_A : WS_B;
    endfunction

    // Transaction-level effect of one completed access on instance i.
    task automatic model_complete(input int i, input logic w, input logic [AW-1:0] a,
                                  input logic [NB-1:0] b, input logic [BW-1:0] d);
        logic [BW-1:0] mask;
        mask = '0;
        for (int l = 0; l < NB; l++) if (b[l]) mask = mask | (BW'(8'hFF) << (8 * l));
        if (int'(a) < DEPTH) begin
            if (w) begin
                mem_m[i][a] = (mem_m[i][a] & ~mask) | (d & mask);
                wr_m[i]++;
            end else begin
                rdata_m[i] = mem_m[i][a];
                rd_m[i]++;
            end
        end else if (!w) begin
            rdata_m[i] = '0;
        end
    endtask

    task automatic check_perf(input int i, input string tag);
`ifdef DM_PERF_EN
        check({tag, "_rd_count"}, rd_count[i], rd_m[i]);
        check({tag, "_wr_count"}, wr_count[i], wr_m[i]);
`endif
    endtask

    // Cycle c after the accept edge: done at WS+1, ready from WS+1 on, rdata holds the model value.
    task automatic check_cycle(input int i, input int c, input bit oor);
        string tag;
        int    ws;
        ws  = ws_of(i);
        tag = $sformatf("dut%0d_c%0d", i, c);
        check({tag, "_done"},  {31'd0, done[i]},  {31'd0, (c == ws + 1)});
        check({tag, "_ready"}, {31'd0, ready[i]}, {31'd0, (c >= ws + 1)});
        check({tag, "_err"},   {31'd0, err[i]},   {31'd0, (c == ws + 1) && oor});
        check({tag, "_rdata"}, rdata[i], rdata_m[i]);
        check_perf(i, tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_dut%0d_ready", tag, i), {31'd0, ready[i]}, 32'd1);
            check($sformatf("%s_dut%0d_done", tag, i),  {31'd0, done[i]},  32'd0);
            check($sformatf("%s_dut%0d_err", tag, i),   {31'd0, err[i]},   32'd0);
            check($sformatf("%s_dut%0d_rdata", tag, i), rdata[i], 32'd0);
            check_perf(i, $sformatf("%s_dut%0d", tag, i));
        end
    endtask

    task automatic clear_model_regs();
        for (int i = 0; i < 2; i++) begin
            rdata_m[i] = '0;
            rd_m[i]    = 0;
            wr_m[i]    = 0;
        end
    endtask

    // One transaction on both instances; with hold=1, req stays high through each busy period.
    task automatic do_op(input logic w, input logic [AW-1:0] a, input logic [NB-1:0] b,
                         input logic [BW-1:0] d, input bit hold);
        bit oor;
        oor = (int'(a) >= DEPTH);
        @(negedge clk);
        for (int i = 0; i < 2; i++) check($sformatf("dut%0d_ready_pre", i), {31'd0, ready[i]}, 32'd1);
        we = w; addr = a; be = b; wdata = d; req = 2'b11;
        @(posedge clk);
        #1;
        if (!hold) req = '0;
        we = 1'($urandom); addr = AW'($urandom); be = NB'($urandom); wdata = $urandom;
        for (int i = 0; i < 2; i++) check_cycle(i, 0, oor);
        for (int c = 1; c <= WS_B + 3; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (c == ws_of(i) + 1) model_complete(i, w, a, b, d);
                check_cycle(i, c, oor);
                if (c == ws_of(i) + 1) req[i] = 1'b0;
            end
        end
    endtask

    initial begin
        logic [BW-1:0] pre_val;
        int            r;
        logic [AW-1:0] ra;

        #2 rst = 1'b0;
        #1 check_reset_outputs("por");
        clear_model_regs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        do_op(1'b1, 10'd5, 4'hF, 32'hDEADBEEF, 1'b0);
        do_op(1'b0, 10'd5, 4'h0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) check($sformatf("dut%0d_rd5", i), rdata[i], 32'hDEADBEEF);

        do_op(1'b1, 10'd7, 4'hF, 32'h11223344, 1'b0);
        do_op(1'b1, 10'd7, 4'b0101, 32'hAABBCCDD, 1'b0);
        do_op(1'b0, 10'd7, 4'hF, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) check($sformatf("dut%0d_lanes", i), rdata[i], 32'h11BB33DD);

        do_op(1'b1, 10'd5, 4'h0, 32'hFFFFFFFF, 1'b1);
        do_op(1'b0, 10'd5, 4'hF, 32'h0, 1'b1);
        for (int i = 0; i < 2; i++) check($sformatf("dut%0d_be0", i), rdata[i], 32'hDEADBEEF);

        do_op(1'b1, 10'd999, 4'hF, 32'h0BADF00D, 1'b0);
        do_op(1'b1, 10'd1000, 4'hF, 32'h00000055, 1'b0);
        do_op(1'b0, 10'd1000, 4'hF, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) check($sformatf("dut%0d_oor_rd", i), rdata[i], 32'h0);
        do_op(1'b0, 10'd999, 4'hF, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) check($sformatf("dut%0d_rd999", i), rdata[i], 32'h0BADF00D);

        // Every in-range address used below gets a known full word first.
        for (int k = 0; k < 25; k++) begin
            ra = (k < 16) ? AW'(k) : AW'(990 + k - 16);
            do_op(1'b1, ra, 4'hF, $urandom, 1'b0);
        end
        for (int n = 0; n < 150; n++) begin
            r  = int'($urandom_range(0, 49));
            ra = (r < 16) ? AW'(r) : (r < 26) ? AW'(990 + r - 16) : AW'(1000 + r - 26);
            do_op(1'($urandom), ra, NB'($urandom), $urandom, 1'($urandom));
        end

        // Write to addr 3 on dut_b only, aborted by reset two edges after accept.
        pre_val = mem_m[1][3];
        @(negedge clk);
        we = 1'b1; addr = 10'd3; be = 4'hF; wdata = 32'h00001234; req = 2'b10;
        @(posedge clk);
        #1 req = '0;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort_c%0d_done", c),  {31'd0, done[1]},  32'd0);
            check($sformatf("abort_c%0d_ready", c), {31'd0, ready[1]}, 32'd0);
        end
        rst = 1'b0;
        clear_model_regs();
        #1 check_reset_outputs("abort_rst");
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("abort_hold");
        rst = 1'b1;
        do_op(1'b0, 10'd3, 4'hF, 32'h0, 1'b0);
        check("abort_rd3", rdata[1], pre_val);

        do_op(1'b1, 10'd4, 4'h3, $urandom, 1'b0);
        do_op(1'b0, 10'd4, 4'hF, 32'h0, 1'b0);
        do_op(1'b0, 10'd1023, 4'hF, 32'h0, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        clear_model_regs();
        #1 check_reset_outputs("final_rst");
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
